// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial shift-chain blocks.
// Build option SERIAL_DESER_PARITY_EN (used by serial_deser) enables the PARITY state.
package serial_pkg;

    localparam int unsigned SERIAL_DEFAULT_WIDTH = 8;

    // Receiver FSM states; PARITY is only reachable when parity is enabled.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } deser_state_t;

    // Even-parity bit over a zero-extended word: 1 when the word has an odd number of ones.
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/deser_out_buf.sv
// Parallel output holding register with valid/ready handshake and overrun detection.
// A load while an unconsumed word is held (and not being taken this cycle) drops the
// incoming word and its flag, and pulses overrun_o for one cycle.
module deser_out_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] word_i,
    input  logic             flag_i,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             flag_o,
    output logic             overrun_o
);

    logic [Width-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             flag_q, flag_d;
    logic             overrun_q, overrun_d;

    // Next-state: accept a new word when empty or when the held word leaves this cycle.
    always_comb begin
        data_d    = data_q;
        flag_d    = flag_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (load_i) begin
            if (!valid_q || ready_i) begin
                data_d  = word_i;
                flag_d  = flag_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            // data_q keeps its last value after the transfer
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '0;
            flag_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            flag_q    <= flag_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign flag_o    = flag_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-in parallel-out receiver: collects framed bits MSB first into a WIDTH-bit word
// and hands it to a double-buffered valid/ready output stage.
// Define SERIAL_DESER_PARITY_EN to expect one even-parity bit after the data bits.
module serial_deser
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             parity_err
);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] done_word;
    logic             done_flag;
    logic             done;
    logic             last_data_bit;

    assign shifted       = {shreg_q[WIDTH-2:0], serial_in};
    assign last_data_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_DESER_PARITY_EN
    // Word is already complete in shreg_q when the parity bit arrives.
    assign done_word = shreg_q;
    assign done_flag = even_parity(32'(shreg_q)) ^ serial_in;
`else
    // Word completes on the last data bit, straight from the shift path.
    logic unused_shreg_msb;
    assign unused_shreg_msb = shreg_q[WIDTH-1];
    assign done_word        = shifted;
    assign done_flag        = 1'b0;
`endif

    // Next-state for FSM, shift register and bit counter; frame_start always resyncs.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // Abort any partial word silently; this bit is the new MSB.
                shreg_d = {{(WIDTH-1){1'b0}}, serial_in};
                cnt_d   = CNT_W'(1);
                state_d = SHIFT;
            end else begin
                unique case (state_q)
                    SHIFT: begin
                        shreg_d = shifted;
                        if (last_data_bit) begin
                            cnt_d = '0;
`ifdef SERIAL_DESER_PARITY_EN
                            state_d = PARITY;
`else
                            done    = 1'b1;
                            state_d = IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`ifdef SERIAL_DESER_PARITY_EN
                    PARITY: begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
`endif
                    default: begin
                        // IDLE: bits outside a frame are ignored
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Receive-path state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    deser_out_buf #(
        .Width (WIDTH)
    ) u_out_buf (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (done),
        .word_i    (done_word),
        .flag_i    (done_flag),
        .ready_i   (par_ready),
        .data_o    (par_out),
        .valid_o   (par_valid),
        .flag_o    (parity_err),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (WIDTH=8).
// Follows SERIAL_DESER_PARITY_EN so the same bench covers both builds.
module tb_serial_deser;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             serial_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             par_ready = 1'b1;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             overrun;
    logic             parity_err;

    int   n_checks = 0;
    int   n_errors = 0;
    logic early_valid = 1'b0;

    always #5 clk = ~clk;

    serial_deser #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .par_out     (par_out),
        .par_valid   (par_valid),
        .par_ready   (par_ready),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected parity flag for a word sent with the given parity bit.
    function automatic logic exp_perr(input logic [7:0] d, input logic pbit);
`ifdef SERIAL_DESER_PARITY_EN
        return (^d) ^ pbit;
`else
        return 1'b0;
`endif
    endfunction

    // Present one bit for exactly one rising edge; returns on the following falling edge.
    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        bit_valid   = 1'b1;
        frame_start = fs;
        @(negedge clk);
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Send a framed word MSB first with `gap` idle cycles between bits.
    task automatic send_word(input logic [7:0] d, input int gap, input logic pbit);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i != WIDTH - 1) repeat (gap) @(negedge clk);
            if (i != WIDTH - 1 && par_valid) early_valid = 1'b1;
            send_bit(d[i], i == WIDTH - 1);
        end
`ifdef SERIAL_DESER_PARITY_EN
        repeat (gap) @(negedge clk);
        if (par_valid) early_valid = 1'b1;
        send_bit(pbit, 1'b0);
`else
        if (pbit === 1'bx) early_valid = 1'b1;
`endif
    endtask

    initial begin
        // Reset asserted between edges: outputs clear at once
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(par_valid), 32'h0);
        check_eq("rst_out", 32'(par_out), 32'h0);
        check_eq("rst_ovr", 32'(overrun), 32'h0);
        check_eq("rst_perr", 32'(parity_err), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_valid", 32'(par_valid), 32'h0);

        // Stray bits outside a frame are ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        check_eq("idle_stray_valid", 32'(par_valid), 32'h0);

        // Basic word, continuous bits
        early_valid = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        check_eq("basic_valid", 32'(par_valid), 32'h1);
        check_eq("basic_out", 32'(par_out), 32'hA5);
        check_eq("basic_ovr", 32'(overrun), 32'h0);
        check_eq("basic_perr", 32'(parity_err), 32'(exp_perr(8'hA5, 1'b0)));
        check_eq("basic_early", 32'(early_valid), 32'h0);
        @(negedge clk);
        check_eq("basic_one_cycle", 32'(par_valid), 32'h0);
        check_eq("basic_hold_out", 32'(par_out), 32'hA5);

        // Gapped bits
        @(negedge clk);
        early_valid = 1'b0;
        send_word(8'h3C, 2, 1'b0);
        check_eq("gap_valid", 32'(par_valid), 32'h1);
        check_eq("gap_out", 32'(par_out), 32'h3C);
        check_eq("gap_early", 32'(early_valid), 32'h0);
        @(negedge clk);
        check_eq("gap_drop_valid", 32'(par_valid), 32'h0);

        // Backpressure and overrun
        @(negedge clk);
        par_ready = 1'b0;
        send_word(8'h11, 0, 1'b0);
        check_eq("bp_first_valid", 32'(par_valid), 32'h1);
        check_eq("bp_first_out", 32'(par_out), 32'h11);
        check_eq("bp_first_ovr", 32'(overrun), 32'h0);
        send_word(8'h22, 0, 1'b0);
        check_eq("bp_ovr_pulse", 32'(overrun), 32'h1);
        check_eq("bp_held_out", 32'(par_out), 32'h11);
        check_eq("bp_held_valid", 32'(par_valid), 32'h1);
        @(negedge clk);
        check_eq("bp_ovr_clear", 32'(overrun), 32'h0);
        check_eq("bp_still_out", 32'(par_out), 32'h11);
        par_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_xfer_valid", 32'(par_valid), 32'h0);
        check_eq("bp_xfer_out", 32'(par_out), 32'h11);

        // Resync: partial word aborted by a new frame_start
        @(negedge clk);
        early_valid = 1'b0;
        send_bit(1'b1, 1'b1);
        repeat (4) send_bit(1'b1, 1'b0);
        send_word(8'hF0, 0, 1'b0);
        check_eq("resync_valid", 32'(par_valid), 32'h1);
        check_eq("resync_out", 32'(par_out), 32'hF0);
        check_eq("resync_ovr", 32'(overrun), 32'h0);
        check_eq("resync_early", 32'(early_valid), 32'h0);
        @(negedge clk);

        // Parity flag (constant 0 when parity is disabled)
        send_word(8'h07, 0, 1'b1);
        check_eq("par_good_valid", 32'(par_valid), 32'h1);
        check_eq("par_good_out", 32'(par_out), 32'h07);
        check_eq("par_good_err", 32'(parity_err), 32'(exp_perr(8'h07, 1'b1)));
        @(negedge clk);
        send_word(8'h07, 0, 1'b0);
        check_eq("par_bad_out", 32'(par_out), 32'h07);
        check_eq("par_bad_err", 32'(parity_err), 32'(exp_perr(8'h07, 1'b0)));
        @(negedge clk);

        // Async reset with a held word and a partial word in flight
        par_ready = 1'b0;
        send_word(8'h5A, 0, 1'b0);
        check_eq("rst2_pre_valid", 32'(par_valid), 32'h1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst2_valid", 32'(par_valid), 32'h0);
        check_eq("rst2_out", 32'(par_out), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        par_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst2_idle_valid", 32'(par_valid), 32'h0);
        send_word(8'hC3, 0, 1'b0);
        check_eq("rst2_next_out", 32'(par_out), 32'hC3);
        check_eq("rst2_next_valid", 32'(par_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
